// File: rtl/cpu7_ifu_imem_bridge.sv
// Fetch-unit bridge to instruction memory: request throttling, cancel
// discard and a registered single-entry response with fetch exceptions.
module cpu7_ifu_imem_bridge #(
  parameter logic [5:0] ADEF_CODE = 6'h08,
  parameter int         MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_valid_f,
  output logic [31:0] inst_rdata_f,
  output logic        inst_ex,
  output logic [5:0]  inst_exccode,
  output logic [1:0]  inst_count,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  localparam logic [1:0] MaxOut = MAX_OUTST[1:0];

  logic [1:0]  outst_q, outst_d;
  logic [1:0]  disc_q, disc_d;
  logic        pend_q, pend_d;
  logic        vld_q, vld_d;
  logic [31:0] data_q, data_d;
  logic        ex_q, ex_d;
  logic [5:0]  code_q, code_d;

  logic aligned;
  logic full;
  logic rv;
  logic drop;
  logic mem_acc;
  logic mis_acc;

  always_comb begin
    aligned = (inst_addr[1:0] == 2'b00);
    full    = (outst_q == MaxOut) & ~mem_rvalid;
    rv      = mem_rvalid & (outst_q != 2'd0);
    drop    = rv & (disc_q != 2'd0);
    mem_req = ~reset & inst_req & aligned & ~full;
    mem_acc = mem_req & mem_addr_ok;
    mis_acc = ~reset & inst_req & ~aligned
            & (outst_q == 2'd0) & ~pend_q;
    inst_addr_ok = mem_acc | mis_acc;
  end

  always_comb begin
    outst_d = outst_q + {1'b0, mem_acc} - {1'b0, rv};
    // discard entries are a subset of outst, so a cancel
    // marks every still-outstanding old request
    if (inst_cancel) disc_d = outst_q - {1'b0, rv};
    else             disc_d = disc_q - {1'b0, drop};
    pend_d = mis_acc;
  end

  always_comb begin
    vld_d  = 1'b0;
    data_d = data_q;
    ex_d   = ex_q;
    code_d = code_q;
    if (inst_cancel) begin
      vld_d = 1'b0;
    end else if (pend_q) begin
      vld_d  = 1'b1;
      data_d = 32'h0;
      ex_d   = 1'b1;
      code_d = ADEF_CODE;
    end else if (rv & ~drop) begin
      vld_d  = 1'b1;
      data_d = mem_rdata;
      ex_d   = mem_rerr;
      code_d = mem_rerr ? ADEF_CODE : 6'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= 2'd0;
      disc_q  <= 2'd0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= 32'h0;
      ex_q    <= 1'b0;
      code_q  <= 6'h00;
    end else begin
      outst_q <= outst_d;
      disc_q  <= disc_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ex_q    <= ex_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rvalid && outst_q == 2'd0));
    end
  end

  assign mem_addr     = inst_addr;
  assign inst_valid_f = vld_q;
  assign inst_rdata_f = data_q;
  assign inst_ex      = ex_q;
  assign inst_exccode = code_q;
  assign inst_count   = outst_q;

endmodule

// File: tb/tb_cpu7_ifu_imem_bridge.sv
// Bench for the fetch bridge: directed scenarios plus random traffic
// checked against a queue-based model of the outstanding stream.
module tb_cpu7_ifu_imem_bridge;

  localparam int         MAXO = 2;
  localparam logic [5:0] ADEF = 6'h08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_cancel = 1'b0;
  logic        inst_addr_ok;
  logic        inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic [1:0]  inst_count;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rerr = 1'b0;

  cpu7_ifu_imem_bridge #(
    .ADEF_CODE(ADEF),
    .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_valid_f(inst_valid_f),
    .inst_rdata_f(inst_rdata_f),
    .inst_ex(inst_ex),
    .inst_exccode(inst_exccode),
    .inst_count(inst_count),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_addr_ok(mem_addr_ok),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .mem_rerr(mem_rerr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // one entry per outstanding memory request; 1 = belongs to a cancelled stream
  bit          q[$];
  logic        m_pend = 1'b0;
  logic        m_vld = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic        m_ex = 1'b0;
  logic [5:0]  m_code = 6'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic rq, input logic [31:0] a,
                      input logic cn, input logic aok, input logic rv_i,
                      input logic er, input logic [31:0] rd);
    logic rv, al, full, e_req, e_mis, e_ok, d;
    @(negedge clk);
    chk("valid", 32'(inst_valid_f), 32'(m_vld));
    chk("count", 32'(inst_count), 32'(q.size()));
    if (m_vld) begin
      chk("rdata", inst_rdata_f, m_data);
      chk("ex", 32'(inst_ex), 32'(m_ex));
      chk("code", 32'(inst_exccode), 32'(m_code));
    end
    rv = rv_i && (q.size() > 0);
    inst_req    = rq;
    inst_addr   = a;
    inst_cancel = cn;
    mem_addr_ok = aok;
    mem_rvalid  = rv;
    mem_rerr    = rv ? er : 1'b0;
    mem_rdata   = rd;
    #1;
    al    = (a[1:0] == 2'b00);
    full  = (q.size() == MAXO) && !rv;
    e_req = rq && al && !full;
    e_mis = rq && !al && (q.size() == 0) && !m_pend;
    e_ok  = (e_req && aok) || e_mis;
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("addr_ok", 32'(inst_addr_ok), 32'(e_ok));
    if (e_req) chk("mem_addr", mem_addr, a);
    d = 1'b1;
    if (rv) d = q.pop_front();
    if (cn) foreach (q[i]) q[i] = 1'b1;
    if (e_req && aok) q.push_back(1'b0);
    m_vld = 1'b0;
    if (!cn && m_pend) begin
      m_vld = 1'b1; m_data = 32'h0; m_ex = 1'b1; m_code = ADEF;
    end else if (!cn && rv && !d) begin
      m_vld = 1'b1; m_data = rd; m_ex = er; m_code = er ? ADEF : 6'h0;
    end
    m_pend = e_mis;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() > 0; k++)
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
    idle();
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h1c000040;
    inst_cancel = 1'b0;
    mem_addr_ok = 1'b1;
    mem_rvalid = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_addr_ok", 32'(inst_addr_ok), 32'h0);
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid_f), 32'h0);
    chk("rst_rdata", inst_rdata_f, 32'h0);
    chk("rst_ex", 32'(inst_ex), 32'h0);
    chk("rst_code", 32'(inst_exccode), 32'h0);
    chk("rst_count", 32'(inst_count), 32'h0);
    inst_req = 1'b0;
    mem_addr_ok = 1'b0;
    reset = 1'b0;
    q.delete();
    m_pend = 1'b0;
    m_vld = 1'b0;
  endtask

  logic        r_rq, r_cn, r_aok, r_rv, r_er;
  logic [31:0] r_a;

  initial begin
    do_reset();
    // single fetch
    step(1, 32'h1c000000, 0, 1, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0, 32'h02800421);
    idle();
    idle();
    // back-pressure at MAX_OUTST, then relief by a same-cycle response
    step(1, 32'h1c000004, 0, 1, 0, 0, 0);
    step(1, 32'h1c000008, 0, 1, 0, 0, 0);
    step(1, 32'h1c00000c, 0, 1, 0, 0, 0);
    step(1, 32'h1c00000c, 0, 1, 1, 0, 32'h11111111);
    drain();
    // cancel with a new-stream request in the same cycle
    step(1, 32'h1c000010, 0, 1, 0, 0, 0);
    step(1, 32'h1c000014, 0, 1, 0, 0, 0);
    step(1, 32'h1c000100, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'haaaaaaaa);
    step(0, 0, 0, 0, 1, 0, 32'hbbbbbbbb);
    step(0, 0, 0, 0, 1, 0, 32'hcccccccc);
    idle();
    idle();
    // cancel coincident with a response
    step(1, 32'h1c000020, 0, 1, 0, 0, 0);
    step(1, 32'h1c000024, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 32'hdead0001);
    step(0, 0, 0, 0, 1, 0, 32'hdead0002);
    step(1, 32'h1c000028, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h00c0ffee);
    idle();
    idle();
    // misaligned fetch, idle and with one request outstanding
    step(1, 32'h1c000002, 0, 1, 0, 0, 0);
    idle();
    idle();
    step(1, 32'h1c000000, 0, 1, 0, 0, 0);
    step(1, 32'h1c000002, 0, 1, 0, 0, 0);
    step(1, 32'h1c000002, 0, 1, 1, 0, 32'h12345678);
    step(1, 32'h1c000002, 0, 1, 0, 0, 0);
    idle();
    idle();
    // memory error response
    step(1, 32'h1c000030, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h55aa55aa);
    idle();
    idle();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      r_rq  = ($urandom_range(0, 9) < 7);
      r_a   = $urandom;
      if ($urandom_range(0, 99) >= 12) r_a[1:0] = 2'b00;
      r_cn  = ($urandom_range(0, 99) < 6);
      r_aok = ($urandom_range(0, 9) < 7);
      r_rv  = ($urandom_range(0, 9) < 4);
      r_er  = ($urandom_range(0, 9) < 2);
      step(r_rq, r_a, r_cn, r_aok, r_rv, r_er, $urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    // reset with two requests in flight
    drain();
    step(1, 32'h1c000040, 0, 1, 0, 0, 0);
    step(1, 32'h1c000044, 0, 1, 0, 0, 0);
    idle();
    do_reset();
    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
